// File: rtl/apb_bridge_pkg.sv
// Definitions shared by the a-side APB arbiter and the asynchronous bridge:
// bus widths and the SETUP/ACCESS sequencer state encoding.
package apb_bridge_pkg;

    localparam int ADDR_WD = 8;
    localparam int DATA_WD = 32;
    localparam int STRB_WD = DATA_WD / 8;
    localparam int PROT_WD = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set bit of eligible at or after rr_ptr, wrapping.
// Purely combinational; no backpressure of its own.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_WD  = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] eligible,
    input  logic [IDX_WD-1:0]  rr_ptr,
    output logic [IDX_WD-1:0]  winner,
    output logic               any_valid
);

    int idx;

    // Scan from the farthest offset down so the nearest eligible slot wins.
    always_comb begin
        winner    = '0;
        any_valid = 1'b0;
        idx       = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (eligible[idx]) begin
                winner    = IDX_WD'(idx);
                any_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/apb_req_arbiter.sv
// Round-robin sequencer sharing one APB master port among NUM_REQ hold-until-done requesters.
// Latency: SETUP one edge after request, >=1 ACCESS cycle; a_pready stalls ACCESS indefinitely.
module apb_req_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_WD = apb_bridge_pkg::ADDR_WD,
    parameter int DATA_WD = apb_bridge_pkg::DATA_WD,
    parameter int STRB_WD = apb_bridge_pkg::STRB_WD,
    parameter int PROT_WD = apb_bridge_pkg::PROT_WD
) (
    input  logic                       a_pclk,
    input  logic                       a_prst_n,
    input  logic [NUM_REQ-1:0]         m_req,
    input  logic [NUM_REQ-1:0]         m_write,
    input  logic [NUM_REQ*ADDR_WD-1:0] m_addr,
    input  logic [NUM_REQ*DATA_WD-1:0] m_wdata,
    input  logic [NUM_REQ*STRB_WD-1:0] m_strb,
    input  logic [NUM_REQ*PROT_WD-1:0] m_prot,
    output logic [NUM_REQ-1:0]         m_done,
    output logic [DATA_WD-1:0]         m_rdata,
    output logic                       a_psel,
    output logic                       a_penable,
    output logic                       a_pwrite,
    output logic [ADDR_WD-1:0]         a_paddr,
    output logic [DATA_WD-1:0]         a_pwdata,
    output logic [STRB_WD-1:0]         a_pstrb,
    output logic [PROT_WD-1:0]         a_pprot,
    input  logic [DATA_WD-1:0]         a_prdata,
    input  logic                       a_pready,
    output logic                       busy
);

    import apb_bridge_pkg::apb_state_e;
    import apb_bridge_pkg::ST_IDLE;
    import apb_bridge_pkg::ST_SETUP;
    import apb_bridge_pkg::ST_ACCESS;

    localparam int                 IDX_WD  = $clog2(NUM_REQ);
    localparam logic [NUM_REQ-1:0] ONE_HOT = NUM_REQ'(1);
    localparam logic [IDX_WD-1:0]  LAST    = IDX_WD'(NUM_REQ - 1);

    apb_state_e          state_q, state_d;
    logic [IDX_WD-1:0]   grant_q, grant_d;
    logic [IDX_WD-1:0]   rr_ptr_q, rr_ptr_d;
    logic                psel_q, psel_d;
    logic                penable_q, penable_d;
    logic                pwrite_q, pwrite_d;
    logic                busy_q, busy_d;
    logic [ADDR_WD-1:0]  paddr_q, paddr_d;
    logic [DATA_WD-1:0]  pwdata_q, pwdata_d;
    logic [STRB_WD-1:0]  pstrb_q, pstrb_d;
    logic [PROT_WD-1:0]  pprot_q, pprot_d;

    logic                complete;
    logic [NUM_REQ-1:0]  done_mask;
    logic [NUM_REQ-1:0]  eligible;
    logic [IDX_WD-1:0]   search_ptr;
    logic [IDX_WD-1:0]   next_ptr;
    logic [IDX_WD-1:0]   winner;
    logic                any_valid;

    assign complete   = (state_q == ST_ACCESS) && a_pready;
    assign next_ptr   = (grant_q == LAST) ? '0 : grant_q + 1'b1;
    // The completing requester still shows m_req on this edge; hide it so it is not re-served.
    assign done_mask  = complete ? (ONE_HOT << grant_q) : '0;
    assign eligible   = m_req & ~done_mask;
    assign search_ptr = complete ? next_ptr : rr_ptr_q;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_WD  (IDX_WD)
    ) u_rr_pick (
        .eligible  (eligible),
        .rr_ptr    (search_ptr),
        .winner    (winner),
        .any_valid (any_valid)
    );

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        rr_ptr_d  = rr_ptr_q;
        psel_d    = psel_q;
        penable_d = penable_q;
        pwrite_d  = pwrite_q;
        busy_d    = busy_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        pstrb_d   = pstrb_q;
        pprot_d   = pprot_q;

        unique case (state_q)
            ST_SETUP: begin
                state_d   = ST_ACCESS;
                penable_d = 1'b1;
            end
            ST_ACCESS: begin
                if (a_pready) begin
                    rr_ptr_d  = next_ptr;
                    penable_d = 1'b0;
                    if (!any_valid) begin
                        state_d = ST_IDLE;
                        psel_d  = 1'b0;
                        busy_d  = 1'b0;
                    end
                end
            end
            default: ;
        endcase

        // New grant from IDLE or straight off a completion edge, with no idle cycle between.
        if (any_valid && ((state_q == ST_IDLE) || complete)) begin
            state_d   = ST_SETUP;
            grant_d   = winner;
            psel_d    = 1'b1;
            penable_d = 1'b0;
            busy_d    = 1'b1;
            pwrite_d  = m_write[winner];
            paddr_d   = m_addr[winner*ADDR_WD +: ADDR_WD];
            pwdata_d  = m_wdata[winner*DATA_WD +: DATA_WD];
            pstrb_d   = m_strb[winner*STRB_WD +: STRB_WD];
            pprot_d   = m_prot[winner*PROT_WD +: PROT_WD];
        end
    end

    always_ff @(posedge a_pclk or negedge a_prst_n) begin
        if (!a_prst_n) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            rr_ptr_q  <= '0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            busy_q    <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            pstrb_q   <= '0;
            pprot_q   <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            rr_ptr_q  <= rr_ptr_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
            busy_q    <= busy_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            pstrb_q   <= pstrb_d;
            pprot_q   <= pprot_d;
        end
    end

    assign m_done    = done_mask;
    assign m_rdata   = a_prdata;
    assign a_psel    = psel_q;
    assign a_penable = penable_q;
    assign a_pwrite  = pwrite_q;
    assign a_paddr   = paddr_q;
    assign a_pwdata  = pwdata_q;
    assign a_pstrb   = pstrb_q;
    assign a_pprot   = pprot_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Randomised bench for apb_req_arbiter: per-requester scoreboard queues checked by a
// negedge monitor against a round-robin reference of which request should be served next.
module tb_apb_req_arbiter;

    localparam int N  = 4;
    localparam int AW = 8;
    localparam int DW = 32;
    localparam int SW = 4;
    localparam int PW = 4;

    typedef struct packed {
        logic          w;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [SW-1:0] strb;
        logic [PW-1:0] prot;
    } txn_t;

    localparam int K_IDLE  = 0;
    localparam int K_SETUP = 1;
    localparam int K_WAIT  = 2;
    localparam int K_DONE  = 3;

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    m_req, m_write, m_done;
    logic [N*AW-1:0] m_addr;
    logic [N*DW-1:0] m_wdata;
    logic [N*SW-1:0] m_strb;
    logic [N*PW-1:0] m_prot;
    logic [DW-1:0]   m_rdata;
    logic            a_psel, a_penable, a_pwrite, a_pready, busy;
    logic [AW-1:0]   a_paddr;
    logic [DW-1:0]   a_pwdata, a_prdata;
    logic [SW-1:0]   a_pstrb;
    logic [PW-1:0]   a_pprot;

    apb_req_arbiter dut (
        .a_pclk    (clk),
        .a_prst_n  (rst_n),
        .m_req     (m_req),
        .m_write   (m_write),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_strb    (m_strb),
        .m_prot    (m_prot),
        .m_done    (m_done),
        .m_rdata   (m_rdata),
        .a_psel    (a_psel),
        .a_penable (a_penable),
        .a_pwrite  (a_pwrite),
        .a_paddr   (a_paddr),
        .a_pwdata  (a_pwdata),
        .a_pstrb   (a_pstrb),
        .a_pprot   (a_pprot),
        .a_prdata  (a_prdata),
        .a_pready  (a_pready),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    int issued = 0;
    int completed = 0;

    txn_t exp_q [N][$];
    logic [N-1:0] done_snap = '0;
    logic [N-1:0] reraise = '0;
    bit           rand_en = 0;
    bit           hold_wait = 0;

    // Reference model state: pointer, last observed phase, requests seen before the coming edge.
    int           ptr = 0;
    int           prev_kind = K_IDLE;
    logic [N-1:0] prev_req = '0;
    logic [N-1:0] prev_mask = '0;
    bit           cur_act = 0;
    int           cur_g = 0;
    txn_t         cur_t;

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic int pick(input logic [N-1:0] e, input int start);
        for (int k = 0; k < N; k++)
            if (e[(start + k) % N]) return (start + k) % N;
        return -1;
    endfunction

    task automatic issue(input int i, input logic w, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wd, input logic [SW-1:0] st, input logic [PW-1:0] pr);
        txn_t t;
        t = '{w: w, addr: addr, wdata: wd, strb: st, prot: pr};
        exp_q[i].push_back(t);
        m_write[i]            = w;
        m_addr[i*AW +: AW]    = addr;
        m_wdata[i*DW +: DW]   = wd;
        m_strb[i*SW +: SW]    = st;
        m_prot[i*PW +: PW]    = pr;
        m_req[i]              = 1'b1;
        issued++;
    endtask

    task automatic issue_rand(input int i);
        issue(i, 1'($urandom_range(0, 1)), AW'($urandom), $urandom, SW'($urandom), PW'($urandom));
    endtask

    // One clock of requester and slave behaviour, driven just after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (m_req[i] && done_snap[i]) begin
                m_req[i] = 1'b0;
                if (reraise[i]) begin
                    reraise[i] = 1'b0;
                    issue_rand(i);
                end
            end else if (!m_req[i] && rand_en && $urandom_range(0, 3) == 0) begin
                issue_rand(i);
            end
        end
        a_pready = a_psel && a_penable && !hold_wait && ($urandom_range(0, 2) != 0);
        a_prdata = $urandom;
    endtask

    task automatic wait_idle(input int budget);
        int c;
        c = 0;
        while ((m_req != '0 || a_psel) && c < budget) begin
            step();
            c++;
        end
        chk(c < budget, "drain_timeout", 64'(c), 64'(budget));
    endtask

    always @(negedge clk) begin
        int   kind;
        int   w;
        bit   done;
        logic [N-1:0] elig, exp_done;
        if (!rst_n) begin
            chk(m_done == '0, "reset_m_done", 64'(m_done), 64'd0);
            chk(!a_psel && !a_penable && !busy, "reset_ctrl", 64'({a_psel, a_penable, busy}), 64'd0);
            if (cur_act) begin
                exp_q[cur_g].push_front(cur_t);
                cur_act = 0;
            end
            ptr       = 0;
            prev_kind = K_IDLE;
            prev_mask = '0;
            prev_req  = m_req;
            done_snap = '0;
        end else begin
            kind = !a_psel ? K_IDLE : (!a_penable ? K_SETUP : K_WAIT);
            if (prev_kind == K_IDLE || prev_kind == K_DONE) begin
                elig = prev_req & ~prev_mask;
                chk(kind == ((elig != '0) ? K_SETUP : K_IDLE), "phase_after_idle_or_done",
                    64'(kind), 64'((elig != '0) ? K_SETUP : K_IDLE));
                if (kind == K_SETUP && elig != '0) begin
                    w = pick(elig, ptr);
                    chk(exp_q[w].size() > 0, "scoreboard_nonempty", 64'(exp_q[w].size()), 64'd1);
                    if (exp_q[w].size() > 0) begin
                        cur_t   = exp_q[w].pop_front();
                        cur_g   = w;
                        cur_act = 1;
                    end
                end
            end else begin
                chk(kind == K_WAIT, "phase_access", 64'(kind), 64'(K_WAIT));
            end
            if (kind != K_IDLE && cur_act)
                chk({a_pwrite, a_paddr, a_pwdata, a_pstrb, a_pprot} == cur_t, "apb_fields",
                    64'({a_pwrite, a_paddr, a_pstrb, a_pprot}), 64'({cur_t.w, cur_t.addr, cur_t.strb, cur_t.prot}));
            chk(busy == (kind != K_IDLE), "busy", 64'(busy), 64'(kind != K_IDLE));
            done     = (kind == K_WAIT) && a_pready && cur_act;
            exp_done = done ? (N'(1) << cur_g) : '0;
            chk(m_done == exp_done, "m_done", 64'(m_done), 64'(exp_done));
            done_snap = m_done;
            if (done) begin
                chk(m_rdata == a_prdata, "m_rdata", 64'(m_rdata), 64'(a_prdata));
                completed++;
                ptr       = (cur_g + 1) % N;
                prev_mask = N'(1) << cur_g;
                cur_act   = 0;
                prev_kind = K_DONE;
            end else begin
                prev_mask = '0;
                prev_kind = kind;
            end
            prev_req = m_req;
        end
    end

    initial begin
        int c;
        rst_n = 1'b0;
        m_req = '0; m_write = '0; m_addr = '0; m_wdata = '0; m_strb = '0; m_prot = '0;
        a_pready = 1'b0; a_prdata = '0;
        #2;
        chk({a_psel, a_penable, a_pwrite, busy} == 4'b0, "init_ctrl", 64'({a_psel, a_penable, a_pwrite, busy}), 64'd0);
        chk({a_paddr, a_pwdata, a_pstrb, a_pprot} == '0, "init_fields", 64'({a_paddr, a_pstrb, a_pprot}), 64'd0);
        chk(m_done == '0, "init_m_done", 64'(m_done), 64'd0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;

        step(); issue(0, 1'b1, 8'h3F, 32'h0000FFFF, 4'hF, 4'h0);
        wait_idle(50);
        step(); issue(1, 1'b0, 8'h7F, 32'h0, 4'h0, 4'h2);
        wait_idle(50);

        step();
        for (int i = 0; i < N; i++) issue_rand(i);
        wait_idle(100);

        step(); issue_rand(2);
        wait_idle(50);
        step(); reraise[3] = 1'b1; issue_rand(3); issue_rand(0);
        wait_idle(100);

        step(); issue(1, 1'b1, 8'h55, 32'hA5A5_5A5A, 4'h3, 4'h1); hold_wait = 1;
        c = 0;
        while (!(a_psel && a_penable) && c < 20) begin step(); c++; end
        chk(a_psel && a_penable, "reach_access", 64'({a_psel, a_penable}), 64'd3);
        step(); step();
        #2 rst_n = 1'b0;
        #1;
        chk({a_psel, a_penable, busy} == 3'b0, "async_reset_ctrl", 64'({a_psel, a_penable, busy}), 64'd0);
        chk(m_done == '0, "async_reset_done", 64'(m_done), 64'd0);
        chk(a_paddr == '0, "async_reset_addr", 64'(a_paddr), 64'd0);
        hold_wait = 0;
        @(negedge clk); @(negedge clk);
        #1 rst_n = 1'b1;
        wait_idle(50);

        rand_en = 1;
        repeat (1500) step();
        rand_en = 0;
        wait_idle(300);

        chk(completed == issued, "all_completed", 64'(completed), 64'(issued));
        for (int i = 0; i < N; i++)
            chk(exp_q[i].size() == 0, "queue_empty", 64'(exp_q[i].size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/apb_req_arbiter.md
Name: apb_req_arbiter

Overview:
- Round-robin arbiter/sequencer that lets NUM_REQ local requesters share the single a-side APB master port of asyn_bridge_top.
- Sits in the a_pclk domain, directly upstream of the bridge.
- Converts a simple hold-until-done request interface into legal APB SETUP/ACCESS sequences.
- Returns completion and read data to the granted requester.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADDR_WD, 8, APB address width.
- DATA_WD, 32, APB data width.
- STRB_WD, 4, write-strobe width (DATA_WD/8).
- PROT_WD, 4, protection field width, same value as the bridge.

Ports:
- a_pclk  in  1  clock, a-side APB clock.
- a_prst_n  in  1  asynchronous active-low reset.
- m_req  in  NUM_REQ  per-requester request; held high until that requester's m_done.
- m_write  in  NUM_REQ  per-requester direction (1 = write).
- m_addr  in  NUM_REQ*ADDR_WD  packed addresses; requester i in slice [i*ADDR_WD +: ADDR_WD].
- m_wdata  in  NUM_REQ*DATA_WD  packed write data.
- m_strb  in  NUM_REQ*STRB_WD  packed strobes.
- m_prot  in  NUM_REQ*PROT_WD  packed prot.
- m_done  out  NUM_REQ  one-hot completion; at most one bit set.
- m_rdata  out  DATA_WD  read data; valid while any m_done bit is high.
- a_psel, a_penable, a_pwrite  out  1 each  APB control to bridge.
- a_paddr  out  ADDR_WD  APB address.
- a_pwdata  out  DATA_WD  APB write data.
- a_pstrb  out  STRB_WD  APB strobes.
- a_pprot  out  PROT_WD  APB prot.
- a_prdata  in  DATA_WD  read data from bridge.
- a_pready  in  1  ready from bridge.
- busy  out  1  high in SETUP or ACCESS.

Behaviour:
- Reset (async, a_prst_n low):
  - state = IDLE, grant = 0, rr_ptr = 0.
  - a_psel, a_penable, a_pwrite, busy = 0; a_paddr, a_pwdata, a_pstrb, a_pprot = 0.
  - m_done = 0, since it is a combinational decode of state.
- FSM states: IDLE, SETUP, ACCESS. All outputs except m_done and m_rdata are registered.
- Arbitration (IDLE, or on a completion edge):
  - Search eligible = m_req & ~done_mask, starting at rr_ptr and wrapping NUM_REQ-1 -> 0.
  - The winner's index is latched into grant.
  - The winner's m_write/addr/wdata/strb/prot are latched into the APB output registers, which stay stable for the whole transfer.
- IDLE: if eligible != 0, next state SETUP (a_psel=1, a_penable=0) one edge after m_req rises. Otherwise stay in IDLE with a_psel=0.
- SETUP: always advance to ACCESS (a_penable=1) on the next edge.
- ACCESS with a_pready=0: hold all outputs and wait; the wait count is unbounded.
- ACCESS with a_pready=1 (completion):
  - m_done[grant] = 1 combinationally in that cycle; m_rdata = a_prdata passthrough.
  - The requester samples done at the same edge and drops m_req.
  - rr_ptr <= (grant+1) mod NUM_REQ.
  - done_mask = one-hot(grant) for this edge only, so the completing requester cannot be re-granted on its own stale m_req.
  - If another eligible request exists: next state SETUP directly (a_psel stays 1, a_penable -> 0, new address/data), with no idle cycle.
  - Otherwise: next state IDLE (a_psel=0, a_penable=0).
- Minimum transfer is 2 cycles (SETUP + 1 ACCESS). Back-to-back throughput is one transfer per 2 + wait cycles.
- A request arriving mid-transfer is never preempting; it is considered only at the completion edge.
- m_req for a requester dropped before its m_done: behaviour undefined (protocol violation). Requester inputs of the granted requester may change after SETUP without effect, because they are latched.
- Reset mid-transfer: outputs return to reset values immediately. The bridge is reset in the same reset domain, so no partial handshake persists.

Decomposition:
- Shared package apb_bridge_pkg:
  - localparams ADDR_WD, DATA_WD, STRB_WD, PROT_WD shared with asyn_bridge_top/slave_mux.
  - FSM state encoding (IDLE=2'd0, SETUP=2'd1, ACCESS=2'd2).
- One sub-module: rr_pick (NUM_REQ). Purely combinational; inputs eligible and rr_ptr, outputs winner index and any_valid. Reusable by a future b-side arbiter.

Test Plan:
- Single write: m_req[0]=1, addr 0x3F, wdata 0x0000FFFF, strb 0xF.
  -> a_psel at edge 1, a_penable at edge 2, a_paddr=0x3F held.
  -> m_done[0] pulses for exactly the a_pready cycle.
  -> IDLE afterwards with a_psel=0.
- Read through bridge + slave_mux: m_req[1]=1, write=0, addr 0x7F.
  -> m_done[1] coincides with a_pready.
  -> m_rdata equals a_prdata in that cycle.
  -> no a_penable glitch during b-side wait states.
- Contention: m_req=4'b1111 simultaneously from IDLE.
  -> grant order 0,1,2,3 with back-to-back SETUP (a_psel never drops).
  -> exactly 4 m_done pulses.
- Fairness/wrap: rr_ptr=3, then requesters 3 and 0 both pending.
  -> 3 served first, then 0.
  -> requester 3 immediately re-raising m_req is served after 0, not before.
- Stale-request mask: single requester 2 keeps m_req high one cycle past m_done.
  -> no second transfer issued for that stale request.
  -> a genuine new request on the following cycle is served.
- Reset mid-ACCESS: assert a_prst_n=0 while a_pready=0.
  -> a_psel/a_penable/busy = 0 asynchronously, m_done=0.
  -> after release, a pending m_req restarts cleanly from SETUP.
